// File: rtl/fdiv_pkg.sv
// Shared types and FP32 special-case classification for the divider scheduler.
package fdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [31:0] QNAN     = 32'h7FC00000;
    localparam logic [7:0]  EXP_ALL1 = 8'hFF;

    // Returns {is_special, canonical_result}; denormals are treated as ordinary
    // finite values and left to the divider.
    function automatic logic [32:0] fp_class(input logic [31:0] a, input logic [31:0] b);
        logic sign;
        logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        logic [32:0] res;
        sign   = a[31] ^ b[31];
        a_nan  = (a[30:23] == EXP_ALL1) && (a[22:0] != 23'h0);
        b_nan  = (b[30:23] == EXP_ALL1) && (b[22:0] != 23'h0);
        a_inf  = (a[30:23] == EXP_ALL1) && (a[22:0] == 23'h0);
        b_inf  = (b[30:23] == EXP_ALL1) && (b[22:0] == 23'h0);
        a_zero = (a[30:0] == 31'h0);
        b_zero = (b[30:0] == 31'h0);
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            res = {1'b1, QNAN};
        end else if (a_inf || (b_zero && !a_zero)) begin
            res = {1'b1, sign, EXP_ALL1, 23'h0};
        end else if (a_zero || b_inf) begin
            res = {1'b1, sign, 31'h0};
        end else begin
            res = {1'b0, 32'h0};
        end
        return res;
    endfunction

endpackage

// File: rtl/fdiv_sched_if.sv
// Request, response and divider-side signals of the FP32 divide scheduler.
// Handshakes: a transfer happens on a rising clk edge where valid & ready are both
// high; the source holds its payload stable while valid is high and ready is low.
interface fdiv_sched_if #(parameter int N_REQ = 4);

    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]   req_valid;
    logic [32*N_REQ-1:0] req_a;
    logic [32*N_REQ-1:0] req_b;
    logic [N_REQ-1:0]   req_ready;
    logic               rsp_valid;
    logic [ID_W-1:0]    rsp_id;
    logic [31:0]        rsp_z;
    logic               rsp_ready;
    logic               div_start;
    logic [31:0]        div_a;
    logic [31:0]        div_b;
    logic [31:0]        div_z;

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready, div_z,
        output req_ready, rsp_valid, rsp_id, rsp_z, div_start, div_a, div_b
    );

    modport master (
        output req_valid, req_a, req_b, rsp_ready, div_z,
        input  req_ready, rsp_valid, rsp_id, rsp_z, div_start, div_a, div_b
    );

endinterface

// File: rtl/fdiv_sched_arb.sv
// Round-robin arbiter: search starts one past the last accepted index.
module rr_arbiter #(
    parameter  int N_REQ = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             en,
    input  logic             accept,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_idx
);

    logic [ID_W-1:0] last;
    logic [ID_W:0]   cand;
    logic            found;

    // One extra bit on cand so last+i never wraps before the modulo reduction.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = {1'b0, last} + (ID_W+1)'(i);
            if (cand >= (ID_W+1)'(N_REQ)) begin
                cand = cand - (ID_W+1)'(N_REQ);
            end
            if (en && !found && req[cand[ID_W-1:0]]) begin
                grant[cand[ID_W-1:0]] = 1'b1;
                grant_idx             = cand[ID_W-1:0];
                found                 = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last <= ID_W'(N_REQ - 1);
        end else if (accept) begin
            last <= grant_idx;
        end
    end

endmodule

// File: rtl/fdiv_sched.sv
// Scheduler for the shared iterative FP32 divider: arbitrates requests, resolves
// IEEE special cases locally, sequences the divider and returns tagged quotients.
module fdiv_sched
    import fdiv_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int DIV_LAT = 4
) (
    input  logic          clk,
    input  logic          rst,
    fdiv_sched_if.slave   bus,
    output logic          busy,
    output state_e        state_dbg
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(DIV_LAT + 1);

    state_e            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [N_REQ-1:0]  grant;
    logic [ID_W-1:0]   grant_idx;
    logic              accept;
    logic              capture;
    logic [31:0]       sel_a, sel_b;
    logic [32:0]       cls;
    logic [ID_W-1:0]   rsp_id_q;
    logic [31:0]       rsp_z_q;
    logic [31:0]       div_a_q, div_b_q;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (bus.req_valid),
        .en        (state == IDLE),
        .accept    (accept),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Grant is one-hot, so an OR-mux selects the winner's operands.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel_a = sel_a | bus.req_a[32*i +: 32];
                sel_b = sel_b | bus.req_b[32*i +: 32];
            end
        end
    end

    assign accept  = |grant;
    assign cls     = fp_class(sel_a, sel_b);
    assign capture = (state == RUN) && (cnt == CNT_W'(DIV_LAT - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept)        state_nxt = cls[32] ? RESP : RUN;
            RUN:  if (capture)       state_nxt = RESP;
            RESP: if (bus.rsp_ready) state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    assign bus.req_ready = grant;
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_z     = rsp_z_q;
    assign bus.div_start = (state == RUN) && (cnt == '0);
    assign bus.div_a     = div_a_q;
    assign bus.div_b     = div_b_q;
    assign busy          = (state != IDLE);
    assign state_dbg     = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            rsp_id_q <= '0;
            rsp_z_q  <= '0;
            div_a_q  <= '0;
            div_b_q  <= '0;
        end else begin
            state <= state_nxt;
            if (state == RUN && !capture) begin
                cnt <= cnt + CNT_W'(1);
            end else begin
                cnt <= '0;
            end
            if (accept) begin
                rsp_id_q <= grant_idx;
                // Divider operands only move for requests that actually use it.
                if (cls[32]) begin
                    rsp_z_q <= cls[31:0];
                end else begin
                    div_a_q <= sel_a;
                    div_b_q <= sel_b;
                end
            end
            if (capture) begin
                rsp_z_q <= bus.div_z;
            end
        end
    end

endmodule

// File: tb/tb_fdiv_sched.sv
// Directed bench for fdiv_sched with a fixed-latency divider model.
module tb_fdiv_sched;
    import fdiv_pkg::*;

    localparam int N_REQ   = 4;
    localparam int DIV_LAT = 4;

    logic   clk = 1'b0;
    logic   rst;
    logic   busy;
    state_e state_dbg;

    always #5 clk = ~clk;

    fdiv_sched_if #(.N_REQ(N_REQ)) bus ();

    fdiv_sched #(.N_REQ(N_REQ), .DIV_LAT(DIV_LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    // Divider model: the answer is visible only in the cycle the scheduler should sample it.
    int unsigned div_cyc = 0;
    logic [31:0] div_ans = '0;
    always @(posedge clk) begin
        if (rst)                                     div_cyc <= 0;
        else if (bus.div_start)                      div_cyc <= 1;
        else if (div_cyc != 0 && div_cyc < DIV_LAT)  div_cyc <= div_cyc + 1;
        else                                         div_cyc <= 0;
    end
    assign bus.div_z = (div_cyc == DIV_LAT - 1) ? div_ans : 32'hDEADBEEF;

    int start_cnt = 0;
    int hs_cnt    = 0;
    always @(posedge clk) begin
        if (bus.div_start === 1'b1) start_cnt <= start_cnt + 1;
        if (bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) hs_cnt <= hs_cnt + 1;
    end

    int n_checks = 0;
    int n_err    = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int idx, input logic [31:0] a, input logic [31:0] b);
        bus.req_a[32*idx +: 32] = a;
        bus.req_b[32*idx +: 32] = b;
        bus.req_valid[idx]      = 1'b1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_req_ready"}, 32'(bus.req_ready), 32'h0);
        check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'h0);
        check({tag, "_rsp_id"},    32'(bus.rsp_id),    32'h0);
        check({tag, "_rsp_z"},     bus.rsp_z,          32'h0);
        check({tag, "_div_start"}, 32'(bus.div_start), 32'h0);
        check({tag, "_div_a"},     bus.div_a,          32'h0);
        check({tag, "_div_b"},     bus.div_b,          32'h0);
        check({tag, "_busy"},      32'(busy),          32'h0);
        check({tag, "_state"},     32'(state_dbg),     32'(IDLE));
    endtask

    logic [31:0] sp_a[8]   = '{32'h3F800000, 32'hBF800000, 32'h00000000, 32'h40000000,
                               32'hC0000000, 32'h7F800000, 32'h3F800000, 32'h7F800000};
    logic [31:0] sp_b[8]   = '{32'h00000000, 32'h00000000, 32'h00000000, 32'h7F800000,
                               32'h7F800000, 32'h7F800000, 32'h7F800001, 32'h40000000};
    logic [31:0] sp_exp[8] = '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'h00000000,
                               32'h80000000, 32'h7FC00000, 32'h7FC00000, 32'h7F800000};

    initial begin
        int s0;
        int h0;
        int n;
        logic [31:0] e;

        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        check_reset_vals("rst0");

        // Normal divide 6.0 / 2.0 from requester 1.
        div_ans = 32'h40400000;
        set_req(1, 32'h40C00000, 32'h40000000);
        #1;
        check("n_rdy", 32'(bus.req_ready), 32'h2);
        step();
        bus.req_valid = '0;
        check("n_start", 32'(bus.div_start), 32'h1);
        check("n_div_a", bus.div_a, 32'h40C00000);
        check("n_div_b", bus.div_b, 32'h40000000);
        check("n_busy",  32'(busy), 32'h1);
        for (int k = 2; k <= DIV_LAT; k++) begin
            step();
            check("n_wait_valid", 32'(bus.rsp_valid), 32'h0);
            check("n_wait_start", 32'(bus.div_start), 32'h0);
        end
        step();
        check("n_rsp_valid", 32'(bus.rsp_valid), 32'h1);
        check("n_rsp_z",     bus.rsp_z,          32'h40400000);
        check("n_rsp_id",    32'(bus.rsp_id),    32'h1);
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        check("n_done_valid", 32'(bus.rsp_valid), 32'h0);
        check("n_done_busy",  32'(busy),          32'h0);

        // Special cases resolved without the divider.
        for (int i = 0; i < 8; i++) begin
            s0 = start_cnt;
            set_req(0, sp_a[i], sp_b[i]);
            #1;
            check("sp_rdy", 32'(bus.req_ready), 32'h1);
            step();
            bus.req_valid = '0;
            check("sp_valid", 32'(bus.rsp_valid), 32'h1);
            check("sp_z",     bus.rsp_z,          sp_exp[i]);
            check("sp_id",    32'(bus.rsp_id),    32'h0);
            bus.rsp_ready = 1'b1;
            step();
            bus.rsp_ready = 1'b0;
            check("sp_no_start", 32'(start_cnt), 32'(s0));
        end
        check("sp_div_a_hold", bus.div_a, 32'h40C00000);

        // Round robin among 0, 2, 3 after a fresh reset.
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_vals("rst1");
        exp_q = '{32'd0, 32'd2, 32'd3, 32'd0, 32'd2, 32'd3};
        set_req(0, 32'h3F800000, 32'h0);
        set_req(2, 32'h3F800000, 32'h0);
        set_req(3, 32'h3F800000, 32'h0);
        bus.rsp_ready = 1'b1;
        #1;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            check("rr_onehot", 32'($onehot0(bus.req_ready)), 32'h1);
            if (|bus.req_ready) begin
                e = exp_q.pop_front();
                check("rr_grant", 32'(bus.req_ready), 32'h1 << e);
            end
            step();
            n++;
        end
        check("rr_left", 32'(exp_q.size()), 32'h0);
        bus.req_valid = '0;
        step();
        bus.rsp_ready = 1'b0;

        // Back-pressure in RESP.
        div_ans = 32'h40400000;
        set_req(2, 32'h40C00000, 32'h40000000);
        #1;
        step();
        bus.req_valid = '0;
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check("hold_reach", 32'(bus.rsp_valid), 32'h1);
        h0 = hs_cnt;
        set_req(0, 32'h3F800000, 32'h0);
        set_req(1, 32'h3F800000, 32'h0);
        set_req(3, 32'h3F800000, 32'h0);
        #1;
        for (int k = 0; k < 5; k++) begin
            check("hold_valid", 32'(bus.rsp_valid), 32'h1);
            check("hold_z",     bus.rsp_z,          32'h40400000);
            check("hold_id",    32'(bus.rsp_id),    32'h2);
            check("hold_rdy",   32'(bus.req_ready), 32'h0);
            step();
        end
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        check("hold_release", 32'(bus.rsp_valid), 32'h0);
        step();
        step();
        check("hold_one_rsp", 32'(hs_cnt), 32'(h0 + 1));

        // Reset two cycles into RUN.
        set_req(3, 32'h40C00000, 32'h40000000);
        #1;
        step();
        bus.req_valid = '0;
        check("rr_run_start", 32'(bus.div_start), 32'h1);
        step();
        rst = 1'b1;
        s0  = start_cnt;
        step();
        rst = 1'b0;
        check_reset_vals("rst2");
        for (int k = 0; k < 6; k++) begin
            step();
            check("rst2_no_rsp", 32'(bus.rsp_valid), 32'h0);
        end
        check("rst2_no_start", 32'(start_cnt), 32'(s0));
        set_req(0, 32'h3F800000, 32'h0);
        set_req(1, 32'h3F800000, 32'h0);
        #1;
        check("rst2_first", 32'(bus.req_ready), 32'h1);
        step();
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fdiv_sched.md
# fdiv_sched

Request scheduler and sequencer for the shared iterative FP32 divider. Accepts divide requests from `N_REQ` clients over valid/ready, arbitrates round-robin, drives the divider's start/operand inputs, and counts its fixed iteration latency. Captures the quotient and returns it with the requester ID. IEEE special cases (NaN, inf, zero operands) are resolved locally without occupying the divider.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `DIV_LAT`, 4: cycles from `div_start` to valid `div_z` (seed plus Newton iterations).
- `clk`  in  1: clock; all logic on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  N_REQ: per-requester request.
- `req_a`  in  32*N_REQ: dividend, FP32; slice i = bits [32i+31:32i].
- `req_b`  in  32*N_REQ: divisor, FP32.
- `req_ready`  out  N_REQ: one-hot accept; at most one bit high.
- `rsp_valid`  out  1: result available.
- `rsp_id`  out  $clog2(N_REQ): requester index of result.
- `rsp_z`  out  32: quotient.
- `rsp_ready`  in  1: consumer accepts result.
- `div_start`  out  1: one-cycle start pulse to divider.
- `div_a`, `div_b`  out  32: operands to divider.
- `div_z`  in  32: divider result.
- `busy`  out  1: high whenever state is not IDLE.

## Operation
- States: IDLE, RUN, RESP.
- IDLE: round-robin grant `g` among `req_valid`. Search starts at `last+1` mod N_REQ. After reset, `last` = N_REQ-1, so index 0 has priority. `req_ready[g]` is asserted combinationally only in IDLE. On accept, latch `a`, `b`, and `id=g`, and set `last=g`.
- Classification on accept. Sign = a[31]^b[31]. Priority order:
  - NaN: either operand is NaN, 0/0, or inf/inf. Result 32'h7FC00000, sign ignored.
  - inf: a is inf, or b is zero with a nonzero. Result {sign, 8'hFF, 23'h0}.
  - zero: a is zero, or b is inf. Result {sign, 31'h0}.
  - Denormals are not special-cased; they go to the divider.
- Special case: go to RESP with the canonical result; `div_start` is never pulsed.
- Normal case: go to RUN.
  - Pulse `div_start` in the first RUN cycle.
  - `div_a`/`div_b` hold the latched operands for the whole RUN.
  - Cycle counter runs 0..DIV_LAT. `div_z` is captured when the counter equals DIV_LAT-1, counting from the start cycle; then go to RESP.
- RESP: `rsp_valid`=1, and `rsp_id`/`rsp_z` are held stable until `rsp_valid & rsp_ready`, then go to IDLE. No acceptance while in RUN or RESP.
- `div_a`/`div_b` hold their last value outside RUN; 0 after reset.

## Timing
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_z`=0, `div_start`=0, `div_a`=`div_b`=0, `busy`=0, state IDLE, `last`=N_REQ-1, counter 0.
- Accept in cycle t:
  - Normal: `div_start`=1 in cycle t+1. `div_z` sampled at the end of cycle t+DIV_LAT. `rsp_valid` rises at cycle t+DIV_LAT+1.
  - Special: `rsp_valid` at t+1.
- Handshake in cycle r returns to IDLE at r+1; the earliest next accept is r+1. No combinational path from `rsp_ready` to `req_ready`.
- A requester dropping `req_valid` without a handshake is legal; no grant is issued to it.
- Simultaneous requests: exactly one granted per IDLE cycle; a continuously requesting client waits at most N_REQ-1 services.
- `rst` in any state: next cycle matches reset values. In-flight request and pending response are discarded, and `div_start` is not re-pulsed.

## Structure
- Package `fdiv_pkg`:
  - state enum;
  - constants `QNAN`=32'h7FC00000, `EXP_ALL1`=8'hFF;
  - function `fp_class(a,b)` returning {is_special, result}.
- Sub-module `rr_arbiter` (N_REQ, last-grant pointer, one-hot grant, update on accept). FSM, counter and capture registers stay in `fdiv_sched`.

## Test plan
- Requester 1 sends 6.0/2.0 (0x40C00000/0x40000000) → `div_start` 1 cycle after accept, `rsp_valid` DIV_LAT+1 cycles after accept, `rsp_z`=0x40400000, `rsp_id`=1.
- 1.0/0.0 (0x3F800000/0x00000000) → `rsp_z`=0x7F800000 at t+1; −1.0/0.0 → 0xFF800000; 0/0 → 0x7FC00000; 2.0/inf → 0x00000000; `div_start` never asserted.
- Requesters 0, 2, 3 all valid continuously, `rsp_ready`=1 → grant order 0, 2, 3, 0, 2, ...; `req_ready` always one-hot.
- Hold `rsp_ready`=0 for 5 cycles in RESP → `rsp_z`/`rsp_id` unchanged, `req_ready`=0 throughout, and one response per request.
- Assert `rst` 2 cycles into RUN → next cycle all outputs at reset values. After reset with requesters 0 and 1 both valid, index 0 is granted first.
